// File: rtl/gun_pos_ctrl_if.sv
// Joystick-to-gun-position bus between the joystick decode and gun_pos_ctrl.
// Carries cnt_4ms, the four directions, recenter, and the position/step outputs.
interface gun_pos_ctrl_if;
    logic       cnt_4ms;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       recenter;
    logic [5:0] gun_h;
    logic [5:0] gun_v;
    logic       step_h;
    logic       step_v;

    modport master (
        output cnt_4ms, left, right, up, down, recenter,
        input  gun_h, gun_v, step_h, step_v
    );

    modport slave (
        input  cnt_4ms, left, right, up, down, recenter,
        output gun_h, gun_v, step_h, step_v
    );
endinterface

// File: rtl/gun_pos_ctrl.sv
// Gun-position controller: turns joystick directions into 6-bit gun_h/gun_v.
// Ports: clock_12, reset_n (sync, active-low), bus (slave: cnt_4ms, left,
// right, up, down, recenter in; gun_h, gun_v, step_h, step_v out).
module gun_pos_ctrl #(
    parameter int MAX_POS     = 62,
    parameter int CENTER      = 31,
    parameter int SLOW_DIV    = 4,
    parameter int ACCEL_TICKS = 32
) (
    input  logic          clock_12,
    input  logic          reset_n,
    gun_pos_ctrl_if.slave bus
);

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_POS  = 2'd1;
    localparam logic [1:0] DIR_NEG  = 2'd2;

    localparam logic [5:0] MAX6     = 6'(MAX_POS);
    localparam logic [5:0] CTR6     = 6'(CENTER);
    localparam logic [5:0] ACC6     = 6'(ACCEL_TICKS);
    localparam logic [5:0] DIV_LAST = 6'(SLOW_DIV - 1);

    typedef struct packed {
        logic [1:0] dir;
        logic [5:0] hold;
        logic [5:0] div;
        logic [5:0] pos;
        logic       step;
    } axis_t;

    localparam axis_t AXIS_CTR = '{
        dir:  DIR_NONE,
        hold: 6'd0,
        div:  6'd0,
        pos:  CTR6,
        step: 1'b0
    };

    // One tick of one axis. inc/dec are the +1/-1 joystick inputs.
    function automatic axis_t axis_next(axis_t cur, logic inc, logic dec);
        axis_t      nx;
        logic [1:0] req;
        logic       mv;
        nx      = cur;
        nx.step = 1'b0;
        mv      = 1'b0;
        unique case (1'b1)
            inc & ~dec: req = DIR_POS;
            dec & ~inc: req = DIR_NEG;
            default:    req = DIR_NONE;
        endcase
        if (req == DIR_NONE) begin
            nx.dir  = DIR_NONE;
            nx.hold = 6'd0;
            nx.div  = 6'd0;
        end else if (req != cur.dir) begin
            // New press or reversal moves at once and restarts cadence.
            mv      = 1'b1;
            nx.dir  = req;
            nx.hold = 6'd1;
            nx.div  = 6'd0;
        end else begin
            if (cur.hold < ACC6) begin
                nx.hold = cur.hold + 6'd1;
            end
            if (cur.hold >= ACC6) begin
                mv = 1'b1;
            end else if (cur.div == DIV_LAST) begin
                mv     = 1'b1;
                nx.div = 6'd0;
            end else begin
                nx.div = cur.div + 6'd1;
            end
        end
        // Saturated moves keep the counters advancing but report no step.
        if (mv && req == DIR_POS && cur.pos != MAX6) begin
            nx.pos  = cur.pos + 6'd1;
            nx.step = 1'b1;
        end else if (mv && req == DIR_NEG && cur.pos != 6'd0) begin
            nx.pos  = cur.pos - 6'd1;
            nx.step = 1'b1;
        end
        return nx;
    endfunction

    logic  cnt_r_q;
    axis_t h_q;
    axis_t h_d;
    axis_t v_q;
    axis_t v_d;
    logic  tick;

    assign tick = bus.cnt_4ms & ~cnt_r_q;

    always_comb begin
        h_d      = h_q;
        v_d      = v_q;
        h_d.step = 1'b0;
        v_d.step = 1'b0;
        if (bus.recenter) begin
            h_d = AXIS_CTR;
            v_d = AXIS_CTR;
        end else if (tick) begin
            h_d = axis_next(h_q, bus.right, bus.left);
            v_d = axis_next(v_q, bus.down, bus.up);
        end
    end

    always_ff @(posedge clock_12) begin
        if (!reset_n) begin
            cnt_r_q <= 1'b0;
            h_q     <= AXIS_CTR;
            v_q     <= AXIS_CTR;
        end else begin
            cnt_r_q <= bus.cnt_4ms;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    assign bus.gun_h  = h_q.pos;
    assign bus.gun_v  = v_q.pos;
    assign bus.step_h = h_q.step;
    assign bus.step_v = v_q.step;

endmodule
